uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among NUM_REQ byte-stream requesters.
- Round-robin grant at packet granularity: a granted requester keeps the transmitter until its byte flagged last has completed (tx_done).
- Sits between client blocks (command responder, debug logger, status reporter) and uart_tx; drives tx_start/tx_data and observes tx_busy/tx_done.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 1..16.
- TIMEOUT_CYC, 65535, idle-in-packet cycles before forced grant release; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the packet.
- req_ready  out  NUM_REQ  byte accepted when req_valid[i] & req_ready[i].
- grant_valid  out  1  a requester currently owns the transmitter.
- grant_id  out  IDW  owning requester index; IDW = max(1, clog2(NUM_REQ)).
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_data  out  8  byte to uart_tx; stable from the tx_start cycle until tx_done.
- tx_busy  in  1  uart_tx busy.
- tx_done  in  1  uart_tx one-cycle frame-complete pulse.
- timeout_err  out  1  one-cycle pulse on forced release; tied to 0 without the macro.

Behaviour:
- Reset values: req_ready=0, grant_valid=0, grant_id=0, tx_start=0, tx_data=0, timeout_err=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, ISSUE, START, WAIT_DONE.
- IDLE:
  - If any req_valid is set, grant the first set index at or after rr_ptr, searching upward and wrapping.
  - Register grant_id and set grant_valid=1; go to ISSUE next cycle.
  - Otherwise remain in IDLE.
- ISSUE:
  - req_ready[grant_id] = !tx_busy. This is combinational; all other req_ready bits are 0.
  - On handshake, latch tx_data=byte and last_q=req_last; go to START.
- START:
  - tx_start=1 for exactly this cycle; go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_done; tx_busy is ignored in this state.
  - On tx_done with last_q=0: go to ISSUE with the same grant.
  - On tx_done with last_q=1: grant_valid=0, rr_ptr=grant_id+1 (wrapping at NUM_REQ-1 to 0), go to IDLE.
- Latency from IDLE with tx_busy=0: req_valid seen in cycle 0 -> grant in cycle 1 -> handshake in cycle 1 -> tx_start in cycle 2.
- Back-to-back bytes in a packet: the next handshake can occur in the cycle after tx_done.
- Grant is never pre-empted mid-packet, even if another requester is valid. The exception is a timeout, available only with the macro.
- If the granted requester deasserts req_valid mid-packet, the block waits in ISSUE indefinitely (no macro).
- Simultaneous valids: rotating priority. Each requester is guaranteed service within NUM_REQ-1 packets of others.
- A single-byte packet (req_last=1 on the first byte) is legal.
- NUM_REQ=1: grant_id is constant 0 and the behaviour is otherwise identical.
- tx_done in any state other than WAIT_DONE is ignored.
- Reset mid-packet:
  - Returns to IDLE on the next edge; all outputs go to their reset values.
  - A byte already in flight in uart_tx completes on the line.
  - Its tx_done is ignored.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on every handshake and every tx_done.
  - It counts while in ISSUE with req_valid[grant_id]=0.
  - On reaching TIMEOUT_CYC: pulse timeout_err for 1 cycle, grant_valid=0, rr_ptr=grant_id+1, go to IDLE.
- Without the macro: no counter is built, timeout_err is tied to 0, and a stalled packet holds the grant indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, START, WAIT_DONE}.
  - MAX_REQ=16 constant.
  - Function idw(n) returning max(1, clog2(n)).
- Sub-module rr_pick: purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and index of the first set bit at or after rr_ptr, with wrap-around.
  - Instantiated once by uart_tx_arbiter.

Test Plan:
- Single request: NUM_REQ=4, req0 sends 0x55 with last=1 -> req_ready[0] in cycle 1, tx_start in cycle 2 with tx_data=0x55, grant_valid=0 the cycle after tx_done.
- Multi-byte packet: req2 sends 0xA1, 0xB2, 0xC3 (last on 0xC3) while req1 is valid -> three tx_start pulses, all with grant_id=2; req1 is granted only after the third tx_done.
- Round-robin fairness: all four requesters continuously send single-byte packets -> grant order 0,1,2,3,0 and rr_ptr wraps from 3 to 0.
- Busy gating: tx_busy held high for 10 cycles while in ISSUE -> req_ready stays 0 throughout, then handshake occurs in the cycle tx_busy falls.
- Reset mid-packet: reset asserted in WAIT_DONE of the second byte of a packet from req3 -> the next cycle shows all outputs at reset values and state IDLE; the late tx_done is ignored and the next grant starts the search from index 0.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=20): req1 drops req_valid after its first non-last byte -> timeout_err pulses 20 cycles into ISSUE, then grant goes to req2 if it is valid.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter.
package uart_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  // Largest supported requester count
  localparam int MAX_REQ = 16;

  // Width of a requester index; never narrower than one bit
  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ
// byte-stream clients. Optional stall timeout: define UART_ARB_TIMEOUT_EN.
//
// Handshake: a byte moves from requester i when req_valid[i] & req_ready[i]
// are both high on a rising clk edge; req_ready is only ever raised for the
// granted requester, and only in ISSUE while uart_tx is not busy.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int IDW         = idw(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_done,
  output logic                 timeout_err,
  output arb_state_t           state
);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 1..16 and TIMEOUT_CYC at least 1");
  end

  logic [7:0]     req_byte [NUM_REQ];
  logic           last_q;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] next_ptr;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           handshake;
  logic           timeout_hit;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[8*g +: 8];
  end

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pointer just past the current owner, wrapping to 0 after the last index
  assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  assign handshake = (state == ISSUE) && !tx_busy && req_valid[grant_id];

  // Only the owner sees ready, and only while uart_tx can take a byte
  always_comb begin
    req_ready = '0;
    if (state == ISSUE && !tx_busy) req_ready[grant_id] = 1'b1;
  end

  // Arbitration FSM with registered grant and uart_tx outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      last_q      <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (handshake) begin
            tx_data  <= req_byte[grant_id];
            last_q   <= req_last[grant_id];
            tx_start <= 1'b1;
            state    <= START;
          end else if (timeout_hit) begin
            grant_valid <= 1'b0;
            rr_ptr      <= next_ptr;
            state       <= IDLE;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // tx_busy is deliberately ignored here; only tx_done ends a byte
          if (tx_done) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  logic [TOW-1:0] stall_cnt;

  assign timeout_hit = (state == ISSUE) && !req_valid[grant_id] &&
                       (stall_cnt == TOW'(TIMEOUT_CYC - 1));

  // Count owner-stalled ISSUE cycles; release the grant when the limit is hit
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (handshake || tx_done || timeout_hit) begin
        stall_cnt <= '0;
      end else if (state == ISSUE && !req_valid[grant_id]) begin
        stall_cnt <= stall_cnt + TOW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model
// and a packet-level round-robin reference.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int W   = 11;  // {last, id, data}

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy, tx_done, timeout_err;
  arb_state_t     state;

  logic uart_busy, busy_force;
  assign tx_busy = uart_busy | busy_force;

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(20)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_valid(grant_valid),
    .grant_id(grant_id), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .timeout_err(timeout_err),
    .state(state)
  );

  logic [8:0]   src_q [N][$];  // per requester {last, data}
  logic [W-1:0] exp_q[$];      // accepted bytes awaiting tx_start
  int tests = 0;
  int fails = 0;

  // reference model state
  int           mdl_ptr = 0;
  bit           owner_active = 0;
  int           owner = 0;
  bit           inflight = 0;
  logic [W-1:0] inflight_v;
  bit           expect_release = 0;
  bit           expect_b2b = 0;
  logic [N-1:0] prev_valid = '0;
  logic [N-1:0] hs_pend = '0;

  function automatic int rr_ref(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // scoreboard step, once per negedge
  task automatic monitor_step();
    logic [N-1:0] hs;
    logic [W-1:0] e;
    int           exp_id;
    if (reset) begin
      owner_active = 0; mdl_ptr = 0; inflight = 0;
      expect_release = 0; expect_b2b = 0; hs_pend = '0;
      exp_q.delete();
      prev_valid = req_valid;
      return;
    end
    if (expect_release) begin
      tests++;
      if (grant_valid !== 1'b0) begin
        fails++; $display("FAIL release: grant_valid=%b required 0", grant_valid);
      end
      expect_release = 0;
    end
    if (expect_b2b) begin
      tests++;
      if (req_ready !== onehot(owner)) begin
        fails++; $display("FAIL back_to_back: req_ready=%b required %b", req_ready, onehot(owner));
      end
      expect_b2b = 0;
    end
    if (grant_valid === 1'b1 && !owner_active) begin
      exp_id = rr_ref(prev_valid, mdl_ptr);
      tests++;
      if (int'(grant_id) != exp_id) begin
        fails++; $display("FAIL grant_pick: grant_id=%0d required %0d", grant_id, exp_id);
      end
      owner_active = 1;
      owner = (exp_id < 0) ? int'(grant_id) : exp_id;
    end
    if (req_ready !== '0) begin
      tests++;
      if (!owner_active || req_ready !== onehot(owner)) begin
        fails++; $display("FAIL ready_owner: req_ready=%b owner=%0d", req_ready, owner);
      end
    end
    hs = req_valid & req_ready;
    hs_pend = hs;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        logic [IDW-1:0] idv;
        idv = i[IDW-1:0];
        exp_q.push_back({req_last[i], idv, req_data[8*i +: 8]});
      end
    end
    if (tx_start === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL tx_start_unexpected: grant_id=%0d tx_data=%h required no start", grant_id, tx_data);
      end else begin
        e = exp_q.pop_front();
        if ({grant_id, tx_data} !== e[9:0]) begin
          fails++; $display("FAIL tx_start_byte: id/data=%h required %h", {grant_id, tx_data}, e[9:0]);
        end
        inflight = 1; inflight_v = e;
      end
    end
    if (tx_done === 1'b1 && inflight) begin
      tests++;
      if (tx_data !== inflight_v[7:0]) begin
        fails++; $display("FAIL tx_data_stable: tx_data=%h required %h", tx_data, inflight_v[7:0]);
      end
      inflight = 0;
      if (inflight_v[10]) begin
        owner_active = 0; mdl_ptr = (owner + 1) % N; expect_release = 1;
      end else if (!busy_force) begin
        expect_b2b = 1;
      end
    end
    if (timeout_err === 1'b1 && owner_active) begin
      owner_active = 0; mdl_ptr = (owner + 1) % N;
    end
    prev_valid = req_valid;
  endtask

  // requester driver step, once per cycle just after posedge
  task automatic drive_step();
    logic [8:0] f;
    for (int i = 0; i < N; i++)
      if (hs_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    hs_pend = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        f = src_q[i][0];
        req_valid[i] = 1'b1; req_last[i] = f[8]; req_data[8*i +: 8] = f[7:0];
      end else begin
        req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  initial begin
    req_valid = '0; req_last = '0; req_data = '0;
    forever begin
      @(negedge clk); monitor_step();
      @(posedge clk); #1; drive_step();
    end
  end

  // uart_tx model: busy for a random frame, done pulse with busy falling
  initial begin
    bit start_seen;
    int frame_left;
    uart_busy = 1'b0; tx_done = 1'b0; frame_left = 0;
    forever begin
      @(negedge clk); start_seen = (tx_start === 1'b1);
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (start_seen) begin
        uart_busy = 1'b1; frame_left = $urandom_range(3, 8);
      end else if (frame_left > 0) begin
        frame_left--;
        if (frame_left == 0) begin tx_done = 1'b1; uart_busy = 1'b0; end
      end
    end
  end

  task automatic push_packet(input int id, input int len);
    for (int b = 0; b < len; b++) src_q[id].push_back({b == len - 1, 8'($urandom)});
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (c < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 &&
           src_q[2].size() == 0 && src_q[3].size() == 0 && !owner_active &&
           !uart_busy && grant_valid === 1'b0)) begin
      @(negedge clk); c++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (c >= budget) begin
      fails++; $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  // collect grant_id of the next n tx_start pulses and compare to exp_ids
  task automatic check_starts(input string name, input int n, input int exp_ids[8]);
    int got, c;
    got = 0; c = 0;
    while (got < n && c < 400) begin
      @(negedge clk); c++;
      if (tx_start === 1'b1) begin
        tests++;
        if (int'(grant_id) != exp_ids[got]) begin
          fails++; $display("FAIL %s[%0d]: grant_id=%0d required %0d", name, got, grant_id, exp_ids[got]);
        end
        got++;
      end
    end
    if (got < n) begin
      tests++; fails++; $display("FAIL %s_timeout: %0d starts seen, required %0d", name, got, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; busy_force = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests += 7;
    if (req_ready !== '0)     begin fails++; $display("FAIL rst_req_ready: %b required 0", req_ready); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL rst_grant_valid: %b required 0", grant_valid); end
    if (grant_id !== '0)      begin fails++; $display("FAIL rst_grant_id: %0d required 0", grant_id); end
    if (tx_start !== 1'b0)    begin fails++; $display("FAIL rst_tx_start: %b required 0", tx_start); end
    if (tx_data !== 8'h00)    begin fails++; $display("FAIL rst_tx_data: %h required 00", tx_data); end
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout_err: %b required 0", timeout_err); end
    if (state !== IDLE)       begin fails++; $display("FAIL rst_state: %0d required IDLE", state); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_single_byte();
    int c;
    @(negedge clk);
    src_q[0].push_back({1'b1, 8'h55});
    @(negedge clk);  // cycle 0: request visible, not yet granted
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_c0_ready: %b required 0000", req_ready); end
    @(negedge clk);  // cycle 1: grant and handshake
    tests += 3;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_c1_ready: %b required 0001", req_ready); end
    if (grant_valid !== 1'b1)  begin fails++; $display("FAIL single_c1_grant: %b required 1", grant_valid); end
    if (grant_id !== 2'd0)     begin fails++; $display("FAIL single_c1_id: %0d required 0", grant_id); end
    @(negedge clk);  // cycle 2: start pulse
    tests += 2;
    if (tx_start !== 1'b1)  begin fails++; $display("FAIL single_c2_start: %b required 1", tx_start); end
    if (tx_data !== 8'h55)  begin fails++; $display("FAIL single_c2_data: %h required 55", tx_data); end
    c = 0;
    while (tx_done !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    @(negedge clk);
    tests++;
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL single_release: grant_valid=%b required 0", grant_valid); end
    wait_idle(100);
  endtask

  task automatic test_multi_byte();
    int c;
    int ids[8];
    ids = '{2, 2, 2, 1, 0, 0, 0, 0};
    @(negedge clk);
    src_q[2].push_back({1'b0, 8'hA1});
    src_q[2].push_back({1'b0, 8'hB2});
    src_q[2].push_back({1'b1, 8'hC3});
    c = 0;
    while (!(grant_valid === 1'b1 && grant_id === 2'd2) && c < 20) begin @(negedge clk); c++; end
    src_q[1].push_back({1'b1, 8'h4D});
    check_starts("multi_order", 4, ids);
    wait_idle(200);
  endtask

  task automatic test_round_robin();
    int ids[8];
    ids = '{0, 1, 2, 3, 0, 1, 2, 3};
    @(negedge clk);
    push_packet(3, 1);  // leaves the pointer wrapped to 0
    wait_idle(100);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin push_packet(i, 1); push_packet(i, 1); end
    check_starts("rr_order", 8, ids);
    wait_idle(400);
  endtask

  task automatic test_busy_gating();
    @(negedge clk);
    busy_force = 1'b1;
    src_q[1].push_back({1'b1, 8'h3C});
    @(negedge clk);  // cycle 0
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if (req_ready !== 4'b0000 || state !== ISSUE) begin
        fails++; $display("FAIL busy_hold[%0d]: req_ready=%b state=%0d required 0000/ISSUE", k, req_ready, state);
      end
    end
    @(posedge clk); #1; busy_force = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0010) begin fails++; $display("FAIL busy_release_ready: %b required 0010", req_ready); end
    wait_idle(100);
  endtask

  task automatic test_stall();
    int c;
    bit saw_err;
    @(negedge clk);
    src_q[1].push_back({1'b0, 8'h11});
    c = 0;
    while (tx_done !== 1'b1 && c < 40) begin @(negedge clk); c++; end
    saw_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) saw_err = 1;
    end
`ifdef UART_ARB_TIMEOUT_EN
    tests += 2;
    if (!saw_err)             begin fails++; $display("FAIL stall_timeout_err: no pulse, required one"); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL stall_timeout_grant: %b required 0", grant_valid); end
`else
    tests += 4;
    if (saw_err)               begin fails++; $display("FAIL stall_timeout_err: pulse seen, required none"); end
    if (grant_valid !== 1'b1)  begin fails++; $display("FAIL stall_grant: %b required 1", grant_valid); end
    if (grant_id !== 2'd1)     begin fails++; $display("FAIL stall_grant_id: %0d required 1", grant_id); end
    if (state !== ISSUE)       begin fails++; $display("FAIL stall_state: %0d required ISSUE", state); end
    src_q[1].push_back({1'b1, 8'h22});
`endif
    wait_idle(200);
  endtask

  task automatic test_reset_mid_packet();
    int c, got;
    int ids[8];
    ids = '{0, 2, 0, 0, 0, 0, 0, 0};
    @(negedge clk);
    push_packet(3, 3);
    got = 0; c = 0;
    while (got < 2 && c < 100) begin
      @(negedge clk); c++;
      if (tx_start === 1'b1) got++;
    end
    for (int i = 0; i < N; i++) src_q[i].delete();
    @(posedge clk); #1; reset = 1'b1;  // second byte is in WAIT_DONE
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    tests += 5;
    if (state !== IDLE)       begin fails++; $display("FAIL midrst_state: %0d required IDLE", state); end
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL midrst_grant: %b required 0", grant_valid); end
    if (grant_id !== '0)      begin fails++; $display("FAIL midrst_grant_id: %0d required 0", grant_id); end
    if (tx_data !== 8'h00)    begin fails++; $display("FAIL midrst_tx_data: %h required 00", tx_data); end
    if (req_ready !== '0)     begin fails++; $display("FAIL midrst_ready: %b required 0", req_ready); end
    c = 0;
    while (tx_done !== 1'b1 && c < 30) begin @(negedge clk); c++; end
    tests++;
    if (c >= 30 || state !== IDLE || grant_valid !== 1'b0) begin
      fails++; $display("FAIL late_done_ignored: state=%0d grant_valid=%b required IDLE/0", state, grant_valid);
    end
    @(negedge clk);
    push_packet(0, 1); push_packet(2, 1);
    check_starts("post_reset_order", 2, ids);
    wait_idle(200);
  endtask

  task automatic test_random();
    for (int r = 0; r < 150; r++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) push_packet($urandom_range(0, N - 1), $urandom_range(1, 3));
    end
    wait_idle(3000);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL random_drain: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_round_robin();
    test_busy_gating();
    test_stall();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
